// File: rtl/shift_reg_seq.sv
// rtl/shift_reg_seq.sv - sequenced WIDTH-bit shift/rotate register with load and bit-reverse
module shift_reg_seq #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amount,
   input  logic [WIDTH-1:0] data_in,
   input  logic             serial_in,
   input  logic             enable,
   output logic [WIDTH-1:0] data_out,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   localparam logic [2:0] M_NOP  = 3'b000;
   localparam logic [2:0] M_SLL  = 3'b001;
   localparam logic [2:0] M_SRL  = 3'b010;
   localparam logic [2:0] M_SRA  = 3'b011;
   localparam logic [2:0] M_ROL  = 3'b100;
   localparam logic [2:0] M_ROR  = 3'b101;
   localparam logic [2:0] M_LOAD = 3'b110;
   localparam logic [2:0] M_REV  = 3'b111;

   logic [0:0]       state;
   logic [AMT_W-1:0] count;
   logic [2:0]       mode_q;
   logic [WIDTH-1:0] step_data;
   logic [WIDTH-1:0] rev_data;
   logic             step_out;

   assign busy = (state == BUSY);

   always_comb begin
      rev_data = '0;
      for (int i = 0; i < WIDTH; i++) begin
         rev_data[i] = data_out[WIDTH-1-i];
      end
   end

   // One single-bit step of the latched shift/rotate command.
   always_comb begin
      step_data = data_out;
      step_out  = serial_out;
      case (mode_q)
         M_SLL: begin
            step_data = {data_out[WIDTH-2:0], serial_in};
            step_out  = data_out[WIDTH-1];
         end
         M_SRL: begin
            step_data = {serial_in, data_out[WIDTH-1:1]};
            step_out  = data_out[0];
         end
         M_SRA: begin
            step_data = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
            step_out  = data_out[0];
         end
         M_ROL: begin
            step_data = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
            step_out  = data_out[WIDTH-1];
         end
         M_ROR: begin
            step_data = {data_out[0], data_out[WIDTH-1:1]};
            step_out  = data_out[0];
         end
         default: begin
            step_data = data_out;
            step_out  = serial_out;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         mode_q     <= M_NOP;
         data_out   <= '0;
         serial_out <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               case (mode)
                  M_NOP:  done <= 1'b1;
                  M_LOAD: begin
                     data_out <= data_in;
                     done     <= 1'b1;
                  end
                  M_REV: begin
                     data_out <= rev_data;
                     done     <= 1'b1;
                  end
                  default: begin
                     // A zero-step shift completes immediately without touching data.
                     if (amount == '0) begin
                        done <= 1'b1;
                     end else begin
                        mode_q <= mode;
                        count  <= amount;
                        state  <= BUSY;
                     end
                  end
               endcase
            end
         end else if (enable) begin
            data_out   <= step_data;
            serial_out <= step_out;
            count      <= count - AMT_W'(1);
            if (count == AMT_W'(1)) begin
               state <= IDLE;
               done  <= 1'b1;
            end
         end
      end
   end

endmodule
